serial_adder: RTL and testbench

- Bit-serial N-bit adder; the inverse operation of the team's combinational full-subtractor cell.
- Accepts two parallel operands plus carry-in via valid/ready.
- Adds LSB-first through a single full-adder bit cell with a registered carry, one bit per clock.
- Returns the parallel sum and carry-out via valid/ready.
- Used as an area-cheap adder and as a round-trip checker for subtractor results (a = diff + b).

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_fa_cell.sv | 14 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder now, subtractor later).
// State encodings and the bit-counter width helper live here so both blocks stay in step.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One extra bit so the counter never wraps at WIDTH-1, including WIDTH=1.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder; the carry register stays with the caller.
// Zero latency, no flow control.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through one full-adder cell.
// Result valid WIDTH cycles after accept; result held in DONE until out_ready, no overlap.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int              CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s, fa_co;
  logic [WIDTH:0]     sum_shift;
  logic               idle_rdy;

  serial_fa_cell u_fa (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    sum_shift = {fa_s, sum_sr_q};
    idle_rdy  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        idle_rdy = 1'b1;
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        carry_d  = fa_co;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // New sum bit enters at the MSB; the concat keeps this legal for WIDTH=1.
        sum_sr_d = sum_shift[WIDTH:1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = sum_shift[WIDTH:1];
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Ready is forced low while reset is held so nothing can be accepted then.
  assign in_ready = idle_rdy & rst_n;
  assign sum      = sum_q;
  assign cout     = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back random checks of serial_adder (WIDTH=8) plus a WIDTH=1 instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;

  logic       in_valid_1, in_ready_1, cin_1, out_valid_1, out_ready_1, cout_1, busy_1;
  logic [0:0] a_1, b_1, sum_1;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .cin(cin_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .cout(cout_1), .busy(busy_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 transaction: accept, latency, result, optional backpressure, handshake.
  task automatic txn(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input int hold, input string tag);
    int         lat;
    logic [8:0] e;
    logic [8:0] r0;
    lat = 0;
    while (!in_ready && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_rdy"}, int'(in_ready), 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
    tick();
    in_valid = 1'b0;
    a = ~ta; b = 8'($urandom); cin = ~tc;
    check({tag, "_busy"}, int'({busy, in_ready}), 2);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    r0 = {cout, sum};
    check({tag, "_res"}, int'(r0), int'(e));
    check({tag, "_done_rdy"}, int'({in_ready, busy}), 0);
    for (int i = 0; i < hold; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
      check({tag, "_hold"}, int'({out_valid, in_ready, cout, sum}), int'({2'b10, e}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, int'({out_valid, in_ready}), 1);
  endtask

  task automatic txn1(input logic x, input logic y, input logic ci);
    int         lat;
    logic [1:0] e;
    a_1 = x; b_1 = y; cin_1 = ci; in_valid_1 = 1'b1; out_ready_1 = 1'b0;
    e = {1'b0, x} + {1'b0, y} + {1'b0, ci};
    tick();
    in_valid_1 = 1'b0;
    lat = 0;
    while (!out_valid_1 && lat < 10) begin
      tick();
      lat++;
    end
    check("w1_lat", lat, 1);
    check($sformatf("w1_row_%0d%0d%0d", x, y, ci), int'({cout_1, sum_1}), int'(e));
    out_ready_1 = 1'b1;
    tick();
    out_ready_1 = 1'b0;
    check("w1_drop", int'({out_valid_1, in_ready_1}), 1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] e;
    int         pushed, got, last_acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_rdy", int'(in_ready), 0);
    rst_n = 1'b1;
    tick();
    check("rst_state", int'({in_ready, out_valid, busy, cout, sum}), int'({3'b100, 9'h000}));
    check("rst_state_w1", int'({in_ready_1, out_valid_1, busy_1, cout_1, sum_1}), 5'b10000);

    for (int r = 0; r < 8; r++) begin
      txn1(r[2], r[1], r[0]);
    end

    txn(8'h3C, 8'h05, 1'b0, 0, "basic");
    txn(8'hFF, 8'h00, 1'b1, 0, "wrap");
    txn(8'hFF, 8'hFF, 1'b1, 0, "max");
    txn(8'hA5, 8'h3B, 1'b0, 5, "bp");

    // Abort in the fourth SHIFT cycle; previous result was non-zero so clearing is visible.
    a = 8'h77; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", int'({in_ready, out_valid, busy, cout, sum}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_idle", int'({in_ready, busy}), 2);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) seen++;
        tick();
      end
      check("abort_no_result", seen, 0);
    end
    txn(8'h10, 8'h20, 1'b0, 0, "post_abort");

    // Back-to-back: in_valid stays high, out_ready stays high.
    out_ready = 1'b1;
    pushed = 0; got = 0; last_acc = -1;
    for (int c = 0; c < 1500 && got < 100; c++) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        check("b2b_res", int'({cout, sum}), int'(e));
        got++;
      end
      if (in_ready) begin
        if (pushed < 100) begin
          ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
          a = ra; b = rb; cin = rc; in_valid = 1'b1;
          exp_q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
          if (last_acc >= 0) check("b2b_ii", c - last_acc, 10);
          last_acc = c;
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", got, 100);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
